// File: rtl/mesh_edge_endpoint.sv
// rtl/mesh_edge_endpoint.sv - far end of one mesh send/ready/data link with per-VC rx/tx buffers
module mesh_edge_endpoint #(
    parameter int PACKET_WIDTH = 64,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    polarity,
    input  logic                    link_si,
    input  logic [PACKET_WIDTH-1:0] link_di,
    output logic                    link_ri,
    output logic                    link_so,
    output logic [PACKET_WIDTH-1:0] link_do,
    input  logic                    link_ro,
    input  logic                    tx_valid,
    input  logic [PACKET_WIDTH-1:0] tx_data,
    output logic                    tx_ready,
    output logic                    rx_valid,
    output logic [PACKET_WIDTH-1:0] rx_data,
    input  logic                    rx_ready,
    output logic                    rx_err,
    output logic [CNT_WIDTH-1:0]    tx_count,
    output logic [CNT_WIDTH-1:0]    rx_count,
    output logic [CNT_WIDTH-1:0]    drop_count
);

    localparam int VC_BIT = PACKET_WIDTH - 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [PACKET_WIDTH-1:0] rx_buf [2];
    logic [PACKET_WIDTH-1:0] tx_buf [2];
    logic [1:0]              rx_full;
    logic [1:0]              tx_full;
    logic [1:0]              rx_full_nxt;
    logic [1:0]              tx_full_nxt;
    logic                    rr;

    logic rx_accept;
    logic rx_drop;
    logic rx_sel;
    logic rx_pop;
    logic tx_vc;
    logic tx_push;

    // Link side: only the buffer matching the current phase may take or give a packet.
    assign link_ri   = ~rx_full[polarity];
    assign rx_accept = link_si && link_ri && (link_di[VC_BIT] == polarity);
    assign rx_drop   = link_si && !rx_accept;

    assign link_so = tx_full[polarity] && link_ro;
    assign link_do = link_so ? tx_buf[polarity] : '0;

    // Host side drain: a lone full buffer wins, otherwise the round-robin pointer decides.
    always_comb begin
        rx_sel = 1'b0;
        case (rx_full)
            2'b10:   rx_sel = 1'b1;
            2'b11:   rx_sel = rr;
            default: rx_sel = 1'b0;
        endcase
    end

    assign rx_valid = |rx_full;
    assign rx_data  = rx_valid ? rx_buf[rx_sel] : '0;
    assign rx_pop   = rx_valid && rx_ready;

    assign tx_vc    = tx_data[VC_BIT];
    assign tx_ready = ~tx_full[tx_vc];
    assign tx_push  = tx_valid && tx_ready;

    // Set and clear never target the same entry: accept needs it empty, pop/send need it full.
    always_comb begin
        rx_full_nxt = rx_full;
        tx_full_nxt = tx_full;
        if (rx_pop)    rx_full_nxt[rx_sel]   = 1'b0;
        if (rx_accept) rx_full_nxt[polarity] = 1'b1;
        if (link_so)   tx_full_nxt[polarity] = 1'b0;
        if (tx_push)   tx_full_nxt[tx_vc]    = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            polarity <= 1'b0;
            rx_full  <= 2'b00;
            tx_full  <= 2'b00;
            rr       <= 1'b0;
        end else begin
            polarity <= ~polarity;
            rx_full  <= rx_full_nxt;
            tx_full  <= tx_full_nxt;
            if (rx_pop && (rx_full == 2'b11)) rr <= ~rx_sel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_buf[0] <= '0;
            rx_buf[1] <= '0;
            tx_buf[0] <= '0;
            tx_buf[1] <= '0;
        end else begin
            if (rx_accept) rx_buf[polarity] <= link_di;
            if (tx_push)   tx_buf[tx_vc]    <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_err     <= 1'b0;
            tx_count   <= '0;
            rx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (rx_drop)   rx_err     <= 1'b1;
            if (rx_drop)   drop_count <= drop_count + CNT_ONE;
            if (rx_accept) rx_count   <= rx_count + CNT_ONE;
            if (link_so)   tx_count   <= tx_count + CNT_ONE;
        end
    end

endmodule

// File: doc/mesh_edge_endpoint.md
Name: mesh_edge_endpoint

Overview:
Terminates one vertical boundary channel of a mesh row: the north edge of the top row, or the open snso/sndo/nsri and snro/nssi/nsdi pairs of a row tile. It is the far end of the router's send/ready/data link and implements both halves. It receives packets from the router into per-VC buffers and sends host packets to the router from per-VC buffers. Even/odd virtual channels are used under a locally generated polarity. The local side is a plain valid/ready stream for a host, bench driver or future inter-row bridge.

Parameters:
PACKET_WIDTH, 64, packet width in bits; the VC bit is PACKET_WIDTH-1.
CNT_WIDTH, 16, width of the tx/rx/drop counters.

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset
polarity  out  1  link phase; VC allowed on the link this cycle
link_si  in  1  router send strobe toward endpoint
link_di  in  PACKET_WIDTH  router data toward endpoint
link_ri  out  1  endpoint ready to router
link_so  out  1  endpoint send strobe toward router
link_do  out  PACKET_WIDTH  endpoint data toward router
link_ro  in  1  router ready toward endpoint
tx_valid  in  1  host packet valid
tx_data  in  PACKET_WIDTH  host packet
tx_ready  out  1  endpoint accepts tx_data
rx_valid  out  1  received packet available
rx_data  out  PACKET_WIDTH  received packet
rx_ready  in  1  host consumes rx_data
rx_err  out  1  sticky link protocol violation
tx_count  out  CNT_WIDTH  packets sent on link
rx_count  out  CNT_WIDTH  packets accepted from link
drop_count  out  CNT_WIDTH  link packets dropped

Behaviour:
- Reset (reset=0, async) clears all of the following:
  - polarity
  - rx_full[1:0], tx_full[1:0]
  - rr pointer
  - rx_err
  - all three counters
  - buffer contents, zeroed
- As a result, after reset: link_so=0, link_ri=1, rx_valid=0, tx_ready=1, link_do=0, rx_data=0. Reset applied mid-transfer discards all buffered packets.
- Polarity: toggles on every rising edge after reset deasserts. The first cycle out of reset has polarity=0. VC(pkt) = pkt[PACKET_WIDTH-1].
- RX buffering:
  - Two 1-entry buffers, rxbuf[0] and rxbuf[1].
  - link_ri = ~rx_full[polarity] (combinational).
  - Accept on an edge when link_si && link_ri && VC(link_di)==polarity: rxbuf[polarity]<=link_di, set full, rx_count+1.
  - link_si with link_ri=0 or VC mismatch: packet dropped, rx_err set (sticky until reset), drop_count+1.
- RX drain:
  - rx_valid = |rx_full.
  - Source selection: if only one buffer is full, that buffer; if both are full, rxbuf[rr].
  - rx_data is the selected buffer; it is 0 when rx_valid=0.
  - On rx_valid && rx_ready, the selected buffer clears at the edge. rr <= ~(selected VC) only when both were full.
  - No bypass: a buffer drained this cycle is refilled at the earliest the next cycle. link_ri uses the start-of-cycle full flag.
- TX fill:
  - tx_ready = ~tx_full[VC(tx_data)] (combinational on tx_data).
  - On tx_valid && tx_ready: txbuf[VC]<=tx_data, set full.
- TX send:
  - link_so = tx_full[polarity] && link_ro.
  - link_do = txbuf[polarity] when link_so, else 0.
  - On an edge with link_so: clear tx_full[polarity], tx_count+1.
  - The host may write the other VC's buffer in the same cycle. The sending buffer is never rewritten in the same cycle, because tx_ready is low while it is full.
- Latency:
  - Host to link: at least 1 cycle; at most 2 cycles plus link_ro stall, since one polarity phase may be waited.
  - Link to host: rx_valid rises the cycle after acceptance.
- Counters wrap: all ones -> 0 with no saturation. Simultaneous RX accept, TX send and host ops in one cycle are all permitted and independent.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release -> polarity=0 then 1,0,1...; link_ri=1, tx_ready=1, link_so=0, rx_valid=0, all counters 0.
- TX per VC: with link_ro=1, host sends 0x0000_0000_0000_00AA (VC0) while polarity=1 -> link_so=1 on the next polarity=0 cycle, link_do=0x...AA, tx_count=1. Then 0x8000_0000_0000_00BB -> sent only on a polarity=1 cycle.
- RX and round-robin: the router sends 0x11 (VC0) on polarity=0 and then 0x8000...0022 (VC1) on polarity=1, with rx_ready=0. Both buffers fill. Then rx_ready=1 -> rx_data order 0x11 (rr=0 from reset), then 0x8000...0022; rx_count=2.
- Backpressure and drop: rxbuf[0] full, rx_ready=0 -> link_ri=0 on polarity=0 cycles. A forced link_si with VC0 -> drop_count=1, rx_err=1, and rxbuf[0] content unchanged.
- VC mismatch: link_si with VC1 data on a polarity=0 cycle with the buffer empty -> dropped, rx_err=1, rx_count unchanged.
- Stall and reset mid-op: link_ro=0 for 10 cycles with both TX buffers full -> link_so stays 0 and tx_ready=0 for both VCs. Then pulse reset=0 asynchronously mid-cycle -> immediate link_so=0, tx_ready=1, buffers empty, tx_count=0.
